// File: rtl/reset_seq.sv
// Reset synchroniser and staggered release sequencer: CH_NUM resets released in order once lock is stable.
// Optional soft-request glitch filter enabled by defining RST_SEQ_FILTER_EN.
module reset_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int CH_NUM       = 4,
  parameter int ASSERT_CYC   = 16,
  parameter int STEP_CYC     = 8,
  parameter bit OUT_POSITIVE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_i,
  input  logic              soft_rst_req,
  output logic [CH_NUM-1:0] rst_o,
  output logic              seq_done
);

  localparam int MAX_CYC = (ASSERT_CYC > STEP_CYC) ? ASSERT_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [CNT_W-1:0]  ASSERT_LAST  = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST    = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(CH_NUM - 1);
  localparam logic [CH_NUM-1:0] ALL_ASSERTED = {CH_NUM{OUT_POSITIVE}};
  localparam logic              REL_LVL      = ~OUT_POSITIVE;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] rst_chain;
  logic [SYNC_STAGES-1:0] lock_chain;
  logic                   rst_s;
  logic                   lock_s;
  logic                   soft_trig;
  logic                   lock_lost;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_nxt;

  // Async assert, sync release of the incoming reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_chain <= '1;
    end else begin
      rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  // Lock indication synchroniser, cleared by the raw reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_chain <= '0;
    end else begin
      lock_chain <= {lock_chain[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign rst_s  = rst_chain[SYNC_STAGES-1];
  assign lock_s = lock_chain[SYNC_STAGES-1];

`ifdef RST_SEQ_FILTER_EN
  logic [1:0] filt_cnt;

  // Counts consecutive high samples; saturates so a held request keeps triggering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= 2'd0;
    end else if (!soft_rst_req) begin
      filt_cnt <= 2'd0;
    end else if (filt_cnt != 2'd3) begin
      filt_cnt <= filt_cnt + 2'd1;
    end else begin
      filt_cnt <= filt_cnt;
    end
  end

  assign soft_trig = soft_rst_req && (filt_cnt == 2'd3);
`else
  assign soft_trig = soft_rst_req;
`endif

  assign lock_lost = !lock_s && ((state_r == ST_RELEASE) || (state_r == ST_DONE));
  assign idx_nxt   = idx_r + IDX_W'(1);

  // Sequencer FSM with registered channel resets and done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_ASSERT;
      cnt_r    <= '0;
      idx_r    <= '0;
      rst_o    <= ALL_ASSERTED;
      seq_done <= 1'b0;
    end else if (rst_s || soft_trig || lock_lost) begin
      state_r  <= ST_ASSERT;
      cnt_r    <= '0;
      idx_r    <= '0;
      rst_o    <= ALL_ASSERTED;
      seq_done <= 1'b0;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          if (cnt_r == ASSERT_LAST) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            idx_r    <= '0;
            cnt_r    <= '0;
            rst_o[0] <= REL_LVL;
            if (CH_NUM == 1) begin
              state_r  <= ST_DONE;
              seq_done <= 1'b1;
            end else begin
              state_r <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_r == STEP_LAST) begin
            cnt_r <= '0;
            idx_r <= idx_nxt;
            for (int i = 0; i < CH_NUM; i++) begin
              if (IDX_W'(i) == idx_nxt) begin
                rst_o[i] <= REL_LVL;
              end
            end
            if (idx_nxt == IDX_LAST) begin
              state_r  <= ST_DONE;
              seq_done <= 1'b1;
            end
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r  <= ST_ASSERT;
          cnt_r    <= '0;
          idx_r    <= '0;
          rst_o    <= ALL_ASSERTED;
          seq_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: per-edge expectations from a timestamp-based model, checked by a negedge monitor.
module tb_reset_seq;

  localparam int SYNC = 2;
  localparam int CH   = 4;
  localparam int ACYC = 16;
  localparam int SCYC = 8;
  localparam bit OPOS = 1'b1;
  localparam logic [CH-1:0] ALL = {CH{OPOS}};

  logic          clk = 1'b0;
  logic          rst;
  logic          lock_i;
  logic          soft_rst_req;
  logic [CH-1:0] rst_o;
  logic          seq_done;
  logic [0:0]    c_rst_o;
  logic          c_done;

  always #5 clk = ~clk;

  reset_seq #(.SYNC_STAGES(SYNC), .CH_NUM(CH), .ASSERT_CYC(ACYC), .STEP_CYC(SCYC), .OUT_POSITIVE(OPOS)) dut (
    .clk(clk), .rst(rst), .lock_i(lock_i), .soft_rst_req(soft_rst_req), .rst_o(rst_o), .seq_done(seq_done)
  );

  reset_seq #(.SYNC_STAGES(2), .CH_NUM(1), .ASSERT_CYC(1), .STEP_CYC(1), .OUT_POSITIVE(1'b0)) u_corner (
    .clk(clk), .rst(rst), .lock_i(lock_i), .soft_rst_req(soft_rst_req), .rst_o(c_rst_o), .seq_done(c_done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [CH-1:0] r;
    logic          d;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: timestamps of restart and first release, channels derived arithmetically.
  int n_edge = 0;
  int rcount = 0;
  bit lk[SYNC];
  int assert_left = ACYC;
  int rel_edge = -1;
  int fcnt = 0;

  function automatic void model_step();
    bit   rs_prev;
    bit   ls_prev;
    bit   trig;
    int   rel;
    exp_t e;
    n_edge++;
    if (rst) begin
      rcount = 0;
      for (int i = 0; i < SYNC; i++) lk[i] = 1'b0;
      assert_left = ACYC;
      rel_edge = -1;
      fcnt = 0;
      e.r = ALL;
      e.d = 1'b0;
      q.push_back(e);
      return;
    end
    rs_prev = (rcount < SYNC);
    ls_prev = lk[SYNC-1];
    fcnt = soft_rst_req ? ((fcnt < 4) ? fcnt + 1 : 4) : 0;
`ifdef RST_SEQ_FILTER_EN
    trig = (fcnt >= 4);
`else
    trig = soft_rst_req;
`endif
    if (rs_prev || trig || (rel_edge >= 0 && !ls_prev)) begin
      assert_left = ACYC;
      rel_edge = -1;
    end else if (assert_left > 0) begin
      assert_left--;
    end else if (rel_edge < 0 && ls_prev) begin
      rel_edge = n_edge;
    end
    if (rcount < SYNC) rcount++;
    for (int i = SYNC - 1; i > 0; i--) lk[i] = lk[i-1];
    lk[0] = lock_i;
    rel = (rel_edge < 0) ? 0 : ((n_edge - rel_edge) / SCYC + 1);
    if (rel > CH) rel = CH;
    for (int i = 0; i < CH; i++) e.r[i] = (i < rel) ? ~OPOS : OPOS;
    e.d = (rel == CH);
    q.push_back(e);
  endfunction

  // Monitor: compare DUT against the oldest expectation on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("sb_rst_o", 32'(rst_o), 32'(mon_e.r));
        check("sb_seq_done", 32'(seq_done), 32'(mon_e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Called 2ns after an edge; asserts rst between edges and checks the immediate effect.
  task automatic async_rst(input int cycles);
    #5;
    rst = 1'b1;
    #1;
    check("async_rst_o", 32'(rst_o), 32'(ALL));
    check("async_seq_done", 32'(seq_done), 32'd0);
    check("async_corner_rst_o", 32'(c_rst_o), 32'd0);
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  int soft_left = 0;

  initial begin
    rst = 1'b1;
    lock_i = 1'b1;
    soft_rst_req = 1'b0;
    for (int i = 0; i < SYNC; i++) lk[i] = 1'b0;

    // Power-on
    repeat (5) tick();
    check("por_corner_rst_o", 32'(c_rst_o), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (e == 3)  begin check("corner_e3_rst_o", 32'(c_rst_o), 32'd0); check("corner_e3_done", 32'(c_done), 32'd0); end
      if (e == 4)  begin check("corner_e4_rst_o", 32'(c_rst_o), 32'd1); check("corner_e4_done", 32'(c_done), 32'd1); end
      if (e == 18) check("por_e18", 32'(rst_o), 32'hF);
      if (e == 19) check("por_e19", 32'(rst_o), 32'hE);
      if (e == 27) check("por_e27", 32'(rst_o), 32'hC);
      if (e == 35) check("por_e35", 32'(rst_o), 32'h8);
      if (e == 42) check("por_e42_done", 32'(seq_done), 32'd0);
      if (e == 43) begin check("por_e43", 32'(rst_o), 32'h0); check("por_e43_done", 32'(seq_done), 32'd1); end
    end

    // Late lock
    lock_i = 1'b0;
    async_rst(5);
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 40) lock_i = 1'b1;
      if (e == 42) check("late_e42", 32'(rst_o), 32'hF);
      if (e == 43) check("late_e43", 32'(rst_o), 32'hE);
      if (e == 66) begin check("late_e66", 32'(rst_o), 32'h8); check("late_e66_done", 32'(seq_done), 32'd0); end
      if (e == 67) begin check("late_e67", 32'(rst_o), 32'h0); check("late_e67_done", 32'(seq_done), 32'd1); end
    end

    // Lock loss in DONE, then replay
    lock_i = 1'b0;
    tick();
    tick();
    check("loss_e2", 32'(rst_o), 32'h0);
    tick();
    check("loss_e3", 32'(rst_o), 32'hF);
    check("loss_e3_done", 32'(seq_done), 32'd0);
    lock_i = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      if (e == 16) check("replay_e16", 32'(rst_o), 32'hF);
      if (e == 17) check("replay_e17", 32'(rst_o), 32'hE);
      if (e == 41) check("replay_e41_done", 32'(seq_done), 32'd1);
    end

    // Soft request during RELEASE
    async_rst(3);
    repeat (30) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
`ifdef RST_SEQ_FILTER_EN
    check("soft_1cyc_ignored", 32'(rst_o), 32'hC);
`else
    check("soft_1cyc_assert", 32'(rst_o), 32'hF);
`endif
    repeat (40) tick();
    for (int k = 1; k <= 4; k++) begin
      soft_rst_req = 1'b1;
      tick();
    end
    check("soft_4cyc_assert", 32'(rst_o), 32'hF);
    soft_rst_req = 1'b0;
    repeat (10) tick();
    soft_rst_req = 1'b1;
    repeat (30) tick();
    soft_rst_req = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      tick();
      if (e == 16) check("hold_e16", 32'(rst_o), 32'hF);
      if (e == 17) check("hold_e17", 32'(rst_o), 32'hE);
    end

    // Async reset in the middle of RELEASE
    async_rst(3);
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e == 18) check("mid_e18", 32'(rst_o), 32'hF);
      if (e == 19) check("mid_e19", 32'(rst_o), 32'hE);
    end
    async_rst(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) async_rst(int'($urandom_range(1, 4)));
      if (lock_i) begin
        if ($urandom_range(0, 149) == 0) lock_i = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) lock_i = 1'b1;
      end
      if (soft_left > 0) begin
        soft_rst_req = 1'b1;
        soft_left--;
      end else begin
        soft_rst_req = 1'b0;
        if ($urandom_range(0, 99) == 0) soft_left = int'($urandom_range(1, 6));
      end
      tick();
    end

    soft_rst_req = 1'b0;
    lock_i = 1'b1;
    repeat (3) tick();
    #10;
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
